fetch_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_sequencer.sv | 136 +++++++++++++
 tb/tb_fetch_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: opcode encodings, fetch FSM states, default widths.
package cpu_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int OP_W_DEF   = 4;

    localparam logic [3:0] OP_HLT = 4'h0;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        HALT
    } fs_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// PC/IR owner and issue FSM; 3 cycles per issued instruction, 2 per jump; PC_WRAP_HALT_EN halts on pc overflow.
// Backpressure: payload and instr_valid hold in ISSUE until instr_ready; pc advances on the handshake.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [OP_W-1:0]   rom_opcode,
    input  logic [OP_W-1:0]   rom_operand,
    input  logic              zero_flag,
    output logic              instr_valid,
    output logic [OP_W-1:0]   instr_opcode,
    output logic [OP_W-1:0]   instr_operand,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    fs_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [OP_W-1:0]   ir_op_q, ir_op_d;
    logic [OP_W-1:0]   ir_opd_q, ir_opd_d;
    logic              vld_q, vld_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [OP_W-1:0]   opd_q, opd_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] jmp_tgt;
    logic              adv_halt;

    assign pc_inc  = pc_q + ADDR_W'(1);
    assign jmp_tgt = ADDR_W'(ir_opd_q);

    // Sequential advance off the top of the address space either wraps or stops.
`ifdef PC_WRAP_HALT_EN
    assign adv_halt = (pc_q == {ADDR_W{1'b1}});
`else
    assign adv_halt = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ir_op_q  <= '0;
            ir_opd_q <= '0;
            vld_q    <= 1'b0;
            op_q     <= '0;
            opd_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_op_q  <= ir_op_d;
            ir_opd_q <= ir_opd_d;
            vld_q    <= vld_d;
            op_q     <= op_d;
            opd_q    <= opd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_op_d  = ir_op_q;
        ir_opd_d = ir_opd_q;
        vld_d    = vld_q;
        op_d     = op_q;
        opd_d    = opd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: begin
                ir_op_d  = rom_opcode;
                ir_opd_d = rom_operand;
                state_d  = DECODE;
            end
            DECODE: begin
                if (ir_op_q == OP_W'(OP_HLT)) begin
                    state_d = HALT;
                end else if (ir_op_q == OP_W'(OP_JMP)) begin
                    pc_d    = jmp_tgt;
                    state_d = FETCH;
                end else if (ir_op_q == OP_W'(OP_JZ)) begin
                    if (zero_flag) begin
                        pc_d    = jmp_tgt;
                        state_d = FETCH;
                    end else begin
                        pc_d    = adv_halt ? pc_q : pc_inc;
                        state_d = adv_halt ? HALT : FETCH;
                    end
                end else begin
                    op_d    = ir_op_q;
                    opd_d   = ir_opd_q;
                    vld_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    vld_d   = 1'b0;
                    pc_d    = adv_halt ? pc_q : pc_inc;
                    state_d = adv_halt ? HALT : FETCH;
                end
            end
            HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == FETCH) || (state_q == DECODE) || (state_q == ISSUE);
        halted = (state_q == HALT);
    end

    assign rom_addr      = pc_q;
    assign pc            = pc_q;
    assign instr_valid   = vld_q;
    assign instr_opcode  = op_q;
    assign instr_operand = opd_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector tables against a bench-held ROM, plus reset/wrap sequences.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] rom_addr;
    logic [3:0] rom_opcode;
    logic [3:0] rom_operand;
    logic       zero_flag = 1'b0;
    logic       instr_valid;
    logic [3:0] instr_opcode;
    logic [3:0] instr_operand;
    logic       instr_ready = 1'b0;
    logic [3:0] pc;
    logic       busy;
    logic       halted;

    logic [7:0] rom [16];

    always #5 clk = ~clk;

    assign rom_opcode  = rom[rom_addr][7:4];
    assign rom_operand = rom[rom_addr][3:0];

    fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .rom_addr      (rom_addr),
        .rom_opcode    (rom_opcode),
        .rom_operand   (rom_operand),
        .zero_flag     (zero_flag),
        .instr_valid   (instr_valid),
        .instr_opcode  (instr_opcode),
        .instr_operand (instr_operand),
        .instr_ready   (instr_ready),
        .pc            (pc),
        .busy          (busy),
        .halted        (halted)
    );

    typedef struct packed {
        logic        start;
        logic        rdy;
        logic        zf;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // {valid, opcode, operand, pc, busy, halted, rom_addr}
    logic [18:0] obs;
    assign obs = {instr_valid, instr_opcode, instr_operand, pc, busy, halted, rom_addr};

    function automatic logic [18:0] e(logic v, logic [3:0] op, logic [3:0] opd,
                                      logic [3:0] p, logic b, logic h);
        return {v, op, opd, p, b, h, p};
    endfunction

    function automatic vec_t row(logic s, logic r, logic z, logic [18:0] x);
        vec_t t;
        t.start = s;
        t.rdy   = r;
        t.zf    = z;
        t.exp   = x;
        return t;
    endfunction

    task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got v=%b op=%h opd=%h pc=%h busy=%b halt=%b addr=%h, want v=%b op=%h opd=%h pc=%h busy=%b halt=%b addr=%h",
                     name, act[18], act[17:14], act[13:10], act[9:6], act[5], act[4], act[3:0],
                     exp[18], exp[17:14], exp[13:10], exp[9:6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    task automatic step(input logic s, input logic r, input logic z);
        start       = s;
        instr_ready = r;
        zero_flag   = z;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        start       = 1'b0;
        instr_ready = 1'b0;
        zero_flag   = 1'b0;
        #2;
        chk("reset_values", obs, e(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            step(tbl[i].start, tbl[i].rdy, tbl[i].zf);
            chk($sformatf("%s[%0d]", name, i), obs, tbl[i].exp);
        end
        tbl.delete();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        // Straight-line program, restart from HALT, start ignored in ISSUE.
        clear_rom();
        rom[0] = 8'h12;
        rom[1] = 8'h25;
        rom[2] = 8'h00;
        do_reset();
        tbl.push_back(row(1'b1, 1'b1, 1'b0, e(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b1, 4'h1, 4'h2, 4'h0, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h1, 4'h2, 4'h1, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h1, 4'h2, 4'h1, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b1, 4'h2, 4'h5, 4'h1, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h2, 4'h5, 4'h2, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h2, 4'h5, 4'h2, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h2, 4'h5, 4'h2, 1'b0, 1'b1)));
        tbl.push_back(row(1'b1, 1'b1, 1'b0, e(1'b0, 4'h2, 4'h5, 4'h0, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h2, 4'h5, 4'h0, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b1, 4'h1, 4'h2, 4'h0, 1'b1, 1'b0)));
        tbl.push_back(row(1'b1, 1'b0, 1'b0, e(1'b1, 4'h1, 4'h2, 4'h0, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h1, 4'h2, 4'h1, 1'b1, 1'b0)));
        run_table("straight");

        // Backpressure, JZ taken, JMP, then JZ not taken on a restart.
        clear_rom();
        rom[0] = 8'h3A;
        rom[1] = 8'hB7;
        rom[2] = 8'h00;
        rom[5] = 8'h51;
        rom[6] = 8'h00;
        rom[7] = 8'hA5;
        do_reset();
        tbl.push_back(row(1'b1, 1'b0, 1'b0, e(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b0, 1'b0, e(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b0, 1'b0, e(1'b1, 4'h3, 4'hA, 4'h0, 1'b1, 1'b0)));
        for (int i = 0; i < 4; i++)
            tbl.push_back(row(1'b0, 1'b0, 1'b1, e(1'b1, 4'h3, 4'hA, 4'h0, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h3, 4'hA, 4'h1, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b0, 1'b0, e(1'b0, 4'h3, 4'hA, 4'h1, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b0, 1'b1, e(1'b0, 4'h3, 4'hA, 4'h7, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b0, 1'b0, e(1'b0, 4'h3, 4'hA, 4'h7, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b0, 1'b0, e(1'b0, 4'h3, 4'hA, 4'h5, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b0, 1'b0, e(1'b0, 4'h3, 4'hA, 4'h5, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b0, 1'b0, e(1'b1, 4'h5, 4'h1, 4'h5, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h5, 4'h1, 4'h6, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h5, 4'h1, 4'h6, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b1, e(1'b0, 4'h5, 4'h1, 4'h6, 1'b0, 1'b1)));
        tbl.push_back(row(1'b1, 1'b0, 1'b0, e(1'b0, 4'h5, 4'h1, 4'h0, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b0, 1'b0, e(1'b0, 4'h5, 4'h1, 4'h0, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b1, 4'h3, 4'hA, 4'h0, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h3, 4'hA, 4'h1, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h3, 4'hA, 4'h1, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h3, 4'hA, 4'h2, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h3, 4'hA, 4'h2, 1'b1, 1'b0)));
        tbl.push_back(row(1'b0, 1'b1, 1'b0, e(1'b0, 4'h3, 4'hA, 4'h2, 1'b0, 1'b1)));
        run_table("jumps");

        // Reset while an instruction is pending at pc=15.
        clear_rom();
        rom[0]  = 8'hAF;
        rom[15] = 8'h4F;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("jmp_to_15", obs, e(1'b0, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0));
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("issue_at_15", obs, e(1'b1, 4'h4, 4'hF, 4'hF, 1'b1, 1'b0));
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_issue", obs, e(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        chk("idle_after_rst", obs, e(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0));

        // Handshake at pc=15, with ROM[0] now holding HLT.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        rom[0] = 8'h00;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("wrap_issue", obs, e(1'b1, 4'h4, 4'hF, 4'hF, 1'b1, 1'b0));
        step(1'b0, 1'b1, 1'b0);
`ifdef PC_WRAP_HALT_EN
        chk("wrap_halt", obs, e(1'b0, 4'h4, 4'hF, 4'hF, 1'b0, 1'b1));
        step(1'b0, 1'b1, 1'b1);
        chk("wrap_halt_hold", obs, e(1'b0, 4'h4, 4'hF, 4'hF, 1'b0, 1'b1));
`else
        chk("wrap_fetch0", obs, e(1'b0, 4'h4, 4'hF, 4'h0, 1'b1, 1'b0));
        step(1'b0, 1'b1, 1'b0);
        chk("wrap_decode0", obs, e(1'b0, 4'h4, 4'hF, 4'h0, 1'b1, 1'b0));
        step(1'b0, 1'b1, 1'b0);
        chk("wrap_halt0", obs, e(1'b0, 4'h4, 4'hF, 4'h0, 1'b0, 1'b1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
